// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//   Buffers fetched {inst, pc_curr, pc_next} in a DEPTH-entry FIFO and presents
//   the FIFO head to an external combinational decoder. The decoder result is
//   registered into a single issue slot and handed to the instruction queue
//   over a valid/ready handshake. The block also owns fetch backpressure,
//   flush/redirect draining and stall accounting.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 redirect: drop everything buffered and registered
//   fetch_valid/_ready    fetch handshake
//   fetch_inst, fetch_pc_curr, fetch_pc_next   fetched data
//   dec_imem_rdata        head instruction to the decoder (0 when empty)
//   dec_fetch_out         head {pc_curr, pc_next} to the decoder (0 when empty)
//   dec_info              decoder result for the head entry
//   iq_valid/iq_info/iq_ready  issue handshake toward the instruction queue
//   occupancy             FIFO entry count
//   stall_cnt             saturating count of cycles iq_valid && !iq_ready
module decode_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int DRAIN_CYC = 1,
  parameter int INFO_W    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_inst,
  input  logic [31:0]              fetch_pc_curr,
  input  logic [31:0]              fetch_pc_next,
  output logic                     fetch_ready,
  output logic [31:0]              dec_imem_rdata,
  output logic [63:0]              dec_fetch_out,
  input  logic [INFO_W-1:0]        dec_info,
  output logic                     iq_valid,
  output logic [INFO_W-1:0]        iq_info,
  input  logic                     iq_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DRAIN_CYC + 1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] DRAIN_W = CW'(DRAIN_CYC);

  typedef enum logic {RUN, DRAIN} state_t;

  // Entry layout: [95:64] inst, [63:32] pc_curr, [31:0] pc_next
  logic [DEPTH-1:0][95:0] mem_q, mem_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            occ_q, occ_d;
  logic                   iq_valid_q, iq_valid_d;
  logic [INFO_W-1:0]      iq_info_q, iq_info_d;
  logic [31:0]            stall_q, stall_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          dcnt_q, dcnt_d;

  logic        head_valid, push, load;
  logic [95:0] head;

  // Readiness depends only on registered state and flush, never on iq_ready.
  always_comb begin
    head_valid  = (occ_q != '0);
    head        = mem_q[rd_ptr_q];
    fetch_ready = (state_q == RUN) && !flush && (occ_q < DEPTH_W);
    push        = fetch_valid && fetch_ready;
    // head_valid comes from registered occupancy, so an entry pushed this
    // cycle into an empty FIFO cannot be loaded until the next cycle.
    load        = head_valid && (!iq_valid_q || iq_ready) && !flush;
    dec_imem_rdata = head_valid ? head[95:64] : '0;
    dec_fetch_out  = head_valid ? head[63:0]  : '0;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    iq_valid_d = iq_valid_q;
    iq_info_d  = iq_info_q;
    stall_d    = stall_q;
    state_d    = state_q;
    dcnt_d     = dcnt_q;

    if (iq_valid_q && !iq_ready && (stall_q != '1))
      stall_d = stall_q + 32'd1;

    if (flush) begin
      // iq_info keeps its stale contents; only the valid bit is cleared.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      iq_valid_d = 1'b0;
      state_d    = DRAIN;
      dcnt_d     = DRAIN_W;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {fetch_inst, fetch_pc_curr, fetch_pc_next};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (load) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        iq_info_d  = dec_info;
        iq_valid_d = 1'b1;
      end else if (iq_valid_q && iq_ready) begin
        iq_valid_d = 1'b0;
      end
      occ_d = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
      if (state_q == DRAIN) begin
        if (dcnt_q == CW'(1)) state_d = RUN;
        else                  dcnt_d  = dcnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      iq_valid_q <= 1'b0;
      iq_info_q  <= '0;
      stall_q    <= '0;
      state_q    <= RUN;
      dcnt_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      iq_valid_q <= iq_valid_d;
      iq_info_q  <= iq_info_d;
      stall_q    <= stall_d;
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign iq_valid  = iq_valid_q;
  assign iq_info   = iq_info_q;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;
  localparam int DEPTH     = 4;
  localparam int DRAIN_CYC = 2;
  localparam int INFO_W    = 64;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, fetch_valid = 1'b0;
  logic [31:0] fetch_inst = '0, fetch_pc_curr = '0, fetch_pc_next = '0;
  logic        fetch_ready, iq_valid, iq_ready = 1'b0;
  logic [31:0] dec_imem_rdata, stall_cnt;
  logic [63:0] dec_fetch_out;
  logic [INFO_W-1:0] dec_info, iq_info;
  logic [$clog2(DEPTH):0] occupancy;

  decode_issue_ctrl #(.DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC), .INFO_W(INFO_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_inst(fetch_inst), .fetch_pc_curr(fetch_pc_curr), .fetch_pc_next(fetch_pc_next),
    .fetch_ready(fetch_ready), .dec_imem_rdata(dec_imem_rdata), .dec_fetch_out(dec_fetch_out),
    .dec_info(dec_info), .iq_valid(iq_valid), .iq_info(iq_info), .iq_ready(iq_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  // Stand-in decoder: {pc_curr, rd, 7'b0, sign-extended imm12 in 20 bits}
  function automatic logic [63:0] dec_f(input logic [31:0] inst, input logic [31:0] pcc);
    return {pcc, inst[11:7], 7'b0, {8{inst[31]}}, inst[31:20]};
  endfunction

  always_comb dec_info = dec_f(dec_imem_rdata, dec_fetch_out[63:32]);

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts and a queue of expected issue results.
  int          m_occ = 0, m_drain = 0;
  bit          m_iqv = 0;
  logic [31:0] m_stall = '0;
  logic [63:0] exp_q[$];

  function automatic bit m_ready();
    return (m_drain == 0) && !flush && (m_occ < DEPTH);
  endfunction

  task automatic model_reset();
    m_occ = 0; m_drain = 0; m_iqv = 0; m_stall = '0; exp_q.delete();
  endtask

  // Called at the rising edge, before inputs change for the next cycle.
  task automatic model_edge();
    bit acc, ld;
    acc = fetch_valid && m_ready();
    ld  = (m_occ > 0) && (!m_iqv || iq_ready) && !flush;
    if (m_iqv && !iq_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush) begin
      m_occ = 0; m_iqv = 0; m_drain = DRAIN_CYC; exp_q.delete();
    end else begin
      if (acc) begin m_occ++; exp_q.push_back(dec_f(fetch_inst, fetch_pc_curr)); end
      if (ld) m_occ--;
      m_iqv = ld ? 1'b1 : (iq_ready ? 1'b0 : m_iqv);
      if (m_drain > 0) m_drain--;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drv(input bit fv, input logic [31:0] inst, input logic [31:0] pcc,
                     input bit iqr, input bit fl);
    fetch_valid = fv; fetch_inst = inst; fetch_pc_curr = pcc; fetch_pc_next = pcc + 32'd4;
    iq_ready = iqr; flush = fl;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [11:0] imm = 12'($urandom);
    logic [4:0]  rd  = 5'($urandom);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  // Monitor: compares outputs to the model mid-cycle and pops on handshakes.
  bit          hold_prev = 0;
  logic [63:0] info_prev = '0;
  always @(negedge clk) begin
    logic [63:0] e;
    chk("fetch_ready", 64'(fetch_ready), 64'(m_ready()));
    chk("occupancy", 64'(occupancy), 64'(m_occ));
    chk("iq_valid", 64'(iq_valid), 64'(m_iqv));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (m_occ == 0) begin
      chk("dec_rdata_empty", 64'(dec_imem_rdata), 64'd0);
      chk("dec_pc_empty", dec_fetch_out, 64'd0);
    end
    if (hold_prev && iq_valid) chk("iq_info_stable", iq_info, info_prev);
    hold_prev = iq_valid && !iq_ready;
    info_prev = iq_info;
    if (iq_valid && iq_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL handshake_unexpected: got %h expected none", iq_info);
      end else begin
        e = exp_q.pop_front();
        chk("iq_info", iq_info, e);
      end
    end
  end

  task automatic drain();
    int k = 0;
    drv(0, '0, '0, 1, 0);
    while ((exp_q.size() != 0 || m_occ != 0 || m_iqv) && k < 200) begin step(); k++; end
    chk("drain_done", 64'(k < 200), 64'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_iq_valid", 64'(iq_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_iq_info", iq_info, 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
  endtask

  task automatic single_instr();
    logic [31:0] pc = 32'h1eceb000;
    drv(1, 32'h00500093, pc, 1, 0);
    step();                        // push edge
    drv(0, '0, '0, 1, 0);
    chk("t1_not_yet", 64'(iq_valid), 64'd0);
    step();                        // load edge
    chk("t1_iq_valid", 64'(iq_valid), 64'd1);
    chk("t1_rd", 64'(iq_info[31:27]), 64'd1);
    chk("t1_imm", 64'(iq_info[19:0]), 64'd5);
    chk("t1_pc", 64'(iq_info[63:32]), 64'(pc));
    step();
    chk("t1_occ_zero", 64'(occupancy), 64'd0);
  endtask

  logic [31:0] pc_g = 32'h0000_1000;

  initial begin
    #23 rst_n = 1'b1;              // release between edges
    chk_reset_vals();

    // 1. single instruction latency
    single_instr();
    drain();

    // 2. backpressure: 6 offered, 5 accepted
    for (int i = 0; i < 6; i++) begin drv(1, rnd_inst(), pc_g, 0, 0); pc_g += 4; step(); end
    chk("t2_full_ready", 64'(fetch_ready), 64'd0);
    chk("t2_full_occ", 64'(occupancy), 64'(DEPTH));
    drv(0, '0, '0, 0, 0);
    repeat (3) step();
    drain();

    // 3. back-to-back stream
    for (int i = 0; i < 16; i++) begin drv(1, rnd_inst(), pc_g, 1, 0); pc_g += 4; step(); end
    drain();

    // 4. flush with buffered entries, push offered during flush, flush in DRAIN
    for (int i = 0; i < 4; i++) begin drv(1, rnd_inst(), pc_g, 0, 0); pc_g += 4; step(); end
    drv(1, rnd_inst(), pc_g, 0, 1); pc_g += 4; step();
    chk("t4_occ", 64'(occupancy), 64'd0);
    chk("t4_iq_valid", 64'(iq_valid), 64'd0);
    for (int i = 0; i < DRAIN_CYC + 2; i++) begin
      drv(1, rnd_inst(), pc_g, 1, 0); pc_g += 4; step();
    end
    drv(1, rnd_inst(), pc_g, 1, 1); pc_g += 4; step();
    drv(1, rnd_inst(), pc_g, 1, 1); pc_g += 4; step();   // restart in DRAIN
    for (int i = 0; i < DRAIN_CYC + 3; i++) begin
      drv(1, rnd_inst(), pc_g, 1, 0); pc_g += 4; step();
    end
    drain();

    // 5. random traffic across pointer wrap, occasional flush
    for (int i = 0; i < 12 * DEPTH; i++) begin
      drv($urandom_range(0, 1) == 1, rnd_inst(), pc_g, $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0);
      pc_g += 4;
      step();
      chk("t5_occ_bound", 64'(occupancy <= DEPTH), 64'd1);
    end
    drain();

    // 6. asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin drv(1, rnd_inst(), pc_g, i[0], 0); pc_g += 4; step(); end
    #2 rst_n = 1'b0;
    model_reset();
    drv(0, '0, '0, 0, 0);
    #1 chk_reset_vals();
    @(posedge clk);
    #3 rst_n = 1'b1;
    single_instr();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
